stream_count_gen: RTL and testbench

Synthesizable valid/ready stream source that emits a programmable arithmetic sequence (seed, step, length) with optional inter-word idle gaps. It is the producer end of the streaming interface that the `ebr_fifo` input port consumes. It replaces bench-only stimulus loops so that FIFO paths can be exercised in hardware. A start pulse launches one burst, and a done pulse reports completion.

---
 rtl/stream_gen_pkg.sv | 10 +
 rtl/stream_count_gen.sv | 143 ++++++++++++++
 tb/tb_stream_count_gen.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_gen_pkg.sv
// Shared types and default sizing for the stream_count_gen sequence source.
package stream_gen_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} gen_state_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_MAX_LEN = 1024;
    localparam int DEF_GAP_W   = 8;

endpackage

// File: rtl/stream_count_gen.sv
// Valid/ready source emitting seed, seed+step, ... for a programmed length,
// with optional idle gaps between words and an early-abort control.
module stream_count_gen
    import stream_gen_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int GAP_W   = DEF_GAP_W
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_length,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [WIDTH-1:0] i_step,
    input  logic [GAP_W-1:0] i_gap,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_sent_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_LEN   = LEN_W'(1);
    localparam logic [GAP_W-1:0] ONE_GAP   = GAP_W'(1);

    gen_state_t       r_state;
    gen_state_t       w_next;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_step;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_sent;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_abort_pend;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_hs;
    logic             w_last;
    logic             w_abort;
    logic             w_capture;
    logic [LEN_W-1:0] w_len_sat;

    // r_valid mirrors SEND, so the handshake never depends on a decoded state
    assign w_hs      = r_valid & i_out_ready;
    assign w_last    = ((r_sent + ONE_LEN) == r_len);
    assign w_abort   = r_abort_pend | i_abort;
    assign w_capture = (r_state == IDLE) & i_start;
    assign w_len_sat = (i_length > MAX_LEN_V) ? MAX_LEN_V : i_length;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = (w_len_sat == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (w_hs) begin
                    if (w_last || w_abort) begin
                        w_next = DONE;
                    end else if (r_gap != '0) begin
                        w_next = GAP;
                    end
                end
            end
            GAP: begin
                if (w_abort) begin
                    w_next = DONE;
                end else if (r_gap_cnt == '0) begin
                    w_next = SEND;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with r_state
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == SEND);
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
            if (w_next == IDLE) begin
                r_abort_pend <= 1'b0;
            end else if (i_abort && (r_state != IDLE)) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data    <= '0;
            r_step    <= '0;
            r_len     <= '0;
            r_sent    <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_data <= i_seed;
                r_step <= i_step;
                r_len  <= w_len_sat;
                r_gap  <= i_gap;
                r_sent <= '0;
            end else if (w_hs) begin
                r_data <= r_data + r_step;
                r_sent <= r_sent + ONE_LEN;
            end

            // Loaded with gap-1 so GAP lasts exactly the captured count of cycles
            if (w_hs) begin
                r_gap_cnt <= r_gap - ONE_GAP;
            end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - ONE_GAP;
            end
        end
    end

    assign o_out_data   = r_data;
    assign o_out_valid  = r_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_sent_count = r_sent;

endmodule

// File: tb/tb_stream_count_gen.sv
// Scoreboard bench for stream_count_gen: directed bursts, gaps, backpressure, abort and reset.
`timescale 1ns/1ps
module tb_stream_count_gen;

    localparam int WIDTH   = 16;
    localparam int MAX_LEN = 1024;
    localparam int LEN_W   = 11;
    localparam int GAP_W   = 8;

    logic             i_clock     = 1'b0;
    logic             i_reset_n   = 1'b0;
    logic             i_start     = 1'b0;
    logic [LEN_W-1:0] i_length    = '0;
    logic [WIDTH-1:0] i_seed      = '0;
    logic [WIDTH-1:0] i_step      = '0;
    logic [GAP_W-1:0] i_gap       = '0;
    logic             i_abort     = 1'b0;
    logic             i_out_ready = 1'b0;
    logic [WIDTH-1:0] o_out_data;
    logic             o_out_valid;
    logic             o_busy;
    logic             o_done;
    logic [LEN_W-1:0] o_sent_count;

    stream_count_gen #(
        .WIDTH   (WIDTH),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .GAP_W   (GAP_W)
    ) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_length     (i_length),
        .i_seed       (i_seed),
        .i_step       (i_step),
        .i_gap        (i_gap),
        .i_abort      (i_abort),
        .o_out_data   (o_out_data),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_sent_count (o_sent_count)
    );

    always #5 i_clock = ~i_clock;

    int               n_checks   = 0;
    int               n_pass     = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold-under-backpressure
    always @(negedge i_clock) begin
        if (!i_reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(o_out_valid), 1);
                chk("hold_data", 32'(o_out_data), 32'(prev_data));
            end
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_word: got %0h, expected no word", o_out_data);
                end else begin
                    chk("word", 32'(o_out_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_data  = o_out_data;
        end
    end

    task automatic push_seq(input logic [WIDTH-1:0] seed, input logic [WIDTH-1:0] step, input int n);
        logic [WIDTH-1:0] v;
        v = seed;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            v = v + step;
        end
    endtask

    task automatic start_burst(input logic [WIDTH-1:0] seed, input logic [WIDTH-1:0] step,
                               input logic [LEN_W-1:0] len, input logic [GAP_W-1:0] gap);
        i_seed   = seed;
        i_step   = step;
        i_length = len;
        i_gap    = gap;
        i_start  = 1'b1;
        @(posedge i_clock); #1;
        i_start  = 1'b0;
    endtask

    // Returns cyc such that o_done is seen in cycle N+cyc after the start edge N
    task automatic wait_done(input int budget, input int ready_pct, output int cyc);
        cyc = 1;
        while (!o_done && cyc < budget) begin
            i_out_ready = ($urandom_range(0, 99) < ready_pct);
            @(posedge i_clock); #1;
            cyc++;
        end
        chk("done_seen", 32'(o_done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int        cyc;
        bit [9:0]  pat;

        // Reset state
        #2;
        chk("rst_valid", 32'(o_out_valid), 0);
        chk("rst_data", 32'(o_out_data), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_sent", 32'(o_sent_count), 0);
        @(posedge i_clock); #1;
        i_reset_n = 1'b1;
        @(posedge i_clock); #1;

        // Basic burst 0..1023, gap 0, ready high
        i_out_ready = 1'b1;
        push_seq(16'd0, 16'd1, 1024);
        start_burst(16'd0, 16'd1, 11'd1024, 8'd0);
        chk("basic_first_valid", 32'(o_out_valid), 1);
        chk("basic_first_data", 32'(o_out_data), 0);
        chk("basic_busy", 32'(o_busy), 1);
        wait_done(3000, 100, cyc);
        chk("basic_done_latency", cyc, 1025);
        chk("basic_sent", 32'(o_sent_count), 1024);
        chk("basic_queue_empty", exp_q.size(), 0);
        @(posedge i_clock); #1;
        chk("basic_busy_fall", 32'(o_busy), 0);
        chk("basic_done_pulse", 32'(o_done), 0);

        // Zero length
        start_burst(16'd5, 16'd1, 11'd0, 8'd0);
        chk("zero_done", 32'(o_done), 1);
        chk("zero_valid", 32'(o_out_valid), 0);
        chk("zero_busy", 32'(o_busy), 1);
        chk("zero_sent", 32'(o_sent_count), 0);
        @(posedge i_clock); #1;
        chk("zero_busy_fall", 32'(o_busy), 0);
        chk("zero_valid_after", 32'(o_out_valid), 0);

        // Gap 2 with wrap-around
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        start_burst(16'hFFFE, 16'd1, 11'd4, 8'd2);
        pat = 10'b1001001001;
        for (int i = 0; i < 10; i++) begin
            chk("gap_valid_pattern", 32'(o_out_valid), 32'(pat[9-i]));
            @(posedge i_clock); #1;
        end
        chk("gap_done", 32'(o_done), 1);
        chk("gap_sent", 32'(o_sent_count), 4);
        // Start offered in the DONE cycle must be dropped
        i_seed   = 16'h1234;
        i_length = 11'd5;
        i_start  = 1'b1;
        @(posedge i_clock); #1;
        i_start  = 1'b0;
        chk("start_in_done_busy", 32'(o_busy), 0);
        chk("start_in_done_valid", 32'(o_out_valid), 0);
        chk("gap_queue_empty", exp_q.size(), 0);

        // Backpressure: ~30% ready, step 3, start/fields changed mid-burst
        i_out_ready = 1'b0;
        push_seq(16'd0, 16'd3, 100);
        start_burst(16'd0, 16'd3, 11'd100, 8'd0);
        for (int i = 0; i < 5; i++) begin
            i_start     = 1'b1;
            i_seed      = 16'h7777;
            i_step      = 16'd9;
            i_length    = 11'd3;
            i_out_ready = ($urandom_range(0, 99) < 30);
            @(posedge i_clock); #1;
        end
        i_start = 1'b0;
        wait_done(5000, 30, cyc);
        chk("bp_sent", 32'(o_sent_count), 100);
        chk("bp_queue_empty", exp_q.size(), 0);
        @(posedge i_clock); #1;

        // Abort while word 10 is stalled
        i_out_ready = 1'b1;
        push_seq(16'd100, 16'd1, 11);
        start_burst(16'd100, 16'd1, 11'd20, 8'd0);
        repeat (10) begin
            @(posedge i_clock); #1;
        end
        i_out_ready = 1'b0;
        i_abort     = 1'b1;
        chk("abort_word10", 32'(o_out_data), 110);
        @(posedge i_clock); #1;
        i_abort = 1'b0;
        repeat (3) begin
            chk("abort_hold_valid", 32'(o_out_valid), 1);
            chk("abort_hold_data", 32'(o_out_data), 110);
            @(posedge i_clock); #1;
        end
        i_out_ready = 1'b1;
        @(posedge i_clock); #1;
        chk("abort_done", 32'(o_done), 1);
        chk("abort_valid_off", 32'(o_out_valid), 0);
        chk("abort_sent", 32'(o_sent_count), 11);
        chk("abort_queue_empty", exp_q.size(), 0);
        @(posedge i_clock); #1;

        // Length above MAX_LEN saturates
        push_seq(16'd5, 16'd2, 1024);
        start_burst(16'd5, 16'd2, 11'd2000, 8'd0);
        wait_done(3000, 100, cyc);
        chk("sat_done_latency", cyc, 1025);
        chk("sat_sent", 32'(o_sent_count), 1024);
        chk("sat_queue_empty", exp_q.size(), 0);
        @(posedge i_clock); #1;

        // Asynchronous reset mid-burst
        push_seq(16'd0, 16'd1, 50);
        start_burst(16'd0, 16'd1, 11'd50, 8'd0);
        repeat (5) begin
            @(posedge i_clock); #1;
        end
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_out_valid), 0);
        chk("arst_data", 32'(o_out_data), 0);
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_sent", 32'(o_sent_count), 0);
        chk("arst_done", 32'(o_done), 0);
        exp_q.delete();
        i_seed   = 16'd9;
        i_length = 11'd4;
        i_start  = 1'b1;
        repeat (2) @(posedge i_clock);
        #1;
        i_start   = 1'b0;
        i_reset_n = 1'b1;
        @(posedge i_clock); #1;
        chk("arst_start_ignored_busy", 32'(o_busy), 0);
        chk("arst_start_ignored_valid", 32'(o_out_valid), 0);
        exp_q.push_back(16'd500);
        exp_q.push_back(16'd501);
        exp_q.push_back(16'd502);
        start_burst(16'd500, 16'd1, 11'd3, 8'd0);
        chk("post_rst_seed", 32'(o_out_data), 500);
        chk("post_rst_valid", 32'(o_out_valid), 1);
        wait_done(100, 100, cyc);
        chk("post_rst_latency", cyc, 4);
        chk("post_rst_sent", 32'(o_sent_count), 3);
        chk("post_rst_queue_empty", exp_q.size(), 0);
        @(posedge i_clock); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
